// File: rtl/vga_vram_scheduler.sv
// Video RAM access scheduler: display reads take priority,
// host writes fill idle RAM cycles via a 4-phase handshake.
module vga_vram_scheduler #(
   parameter int DATA_W        = 3,
   parameter int HPIX_W        = 7,
   parameter int VPIX_W        = 7,
   parameter int ROWS          = 96,
   parameter int LINES_PER_ROW = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [HPIX_W-1:0]        hPixel,
   input  logic                     display_active,
   input  logic                     frame_start,
   input  logic                     host_req,
   input  logic [HPIX_W+VPIX_W-1:0] host_addr,
   input  logic [DATA_W-1:0]        host_wdata,
   output logic                     host_ack,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [HPIX_W+VPIX_W-1:0] mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic [VPIX_W-1:0]        vPixel,
   output logic [DATA_W-1:0]        pix_data,
   output logic                     pix_valid
);

   localparam int ADDR_W = HPIX_W + VPIX_W;
   localparam int LC_W   = (LINES_PER_ROW > 1) ? $clog2(LINES_PER_ROW) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [HPIX_W-1:0]   r_hpix_q;
   logic                r_active_q;
   logic                r_disp_pend;
   logic                r_ack_seen;
   logic [LC_W-1:0]     r_line_cnt;
   logic [VPIX_W-1:0]   r_vpix;
   logic                r_mem_en;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_host_ack;
   logic [DATA_W-1:0]   r_pix_data;
   logic                r_pix_valid;

   logic                w_event;
   logic                w_fall;
   logic                w_host_ok;

   assign w_event   = display_active && (!r_active_q || (hPixel != r_hpix_q));
   assign w_fall    = r_active_q && !display_active;
   assign w_host_ok = host_req && !r_ack_seen;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (r_disp_pend || w_event) begin
               w_next = S_RD;
            end else if (w_host_ok) begin
               w_next = S_WR;
            end
         end
         S_RD: begin
            w_next = S_CAP;
         end
         S_CAP: begin
            if (r_disp_pend) begin
               w_next = S_RD;
            end else if (w_host_ok) begin
               w_next = S_WR;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_WR: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // RAM strobes are registered from the next state so they line up with it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_host_ack  <= 1'b0;
      end else begin
         r_mem_en   <= (w_next == S_RD) || (w_next == S_WR);
         r_mem_we   <= (w_next == S_WR);
         r_host_ack <= (w_next == S_WR);
         if (w_next == S_RD) begin
            r_mem_addr <= {r_vpix, hPixel};
         end else if (w_next == S_WR) begin
            r_mem_addr  <= host_addr;
            r_mem_wdata <= host_wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hpix_q    <= '0;
         r_active_q  <= 1'b0;
         r_disp_pend <= 1'b0;
         r_ack_seen  <= 1'b0;
      end else begin
         r_hpix_q   <= hPixel;
         r_active_q <= display_active;
         if (w_next == S_RD) begin
            r_disp_pend <= 1'b0;
         end else if (w_event) begin
            r_disp_pend <= 1'b1;
         end
         // Block a second write until the host drops its request
         if (r_state == S_WR) begin
            r_ack_seen <= 1'b1;
         end else if (!host_req) begin
            r_ack_seen <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pix_data  <= '0;
         r_pix_valid <= 1'b0;
      end else begin
         r_pix_valid <= (r_state == S_CAP);
         if (w_fall) begin
            r_pix_data <= '0;
         end else if (r_state == S_CAP) begin
            r_pix_data <= mem_rdata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_line_cnt <= '0;
         r_vpix     <= '0;
      end else if (frame_start) begin
         r_line_cnt <= '0;
         r_vpix     <= '0;
      end else if (w_fall) begin
         if (r_line_cnt == LC_W'(LINES_PER_ROW - 1)) begin
            r_line_cnt <= '0;
            if (r_vpix == VPIX_W'(ROWS - 1)) begin
               r_vpix <= '0;
            end else begin
               r_vpix <= r_vpix + VPIX_W'(1);
            end
         end else begin
            r_line_cnt <= r_line_cnt + LC_W'(1);
         end
      end
   end

   assign host_ack  = r_host_ack;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign vPixel    = r_vpix;
   assign pix_data  = r_pix_data;
   assign pix_valid = r_pix_valid;

endmodule

// File: tb/tb_vga_vram_scheduler.sv
// Directed bench for vga_vram_scheduler with a small
// synchronous RAM model and hand-computed expectations.
module tb_vga_vram_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  hPixel;
   logic        display_active;
   logic        frame_start;
   logic        host_req;
   logic [13:0] host_addr;
   logic [2:0]  host_wdata;
   logic        host_ack;
   logic        mem_en;
   logic        mem_we;
   logic [13:0] mem_addr;
   logic [2:0]  mem_wdata;
   logic [2:0]  mem_rdata = '0;
   logic [6:0]  vPixel;
   logic [2:0]  pix_data;
   logic        pix_valid;

   int n_checks = 0;
   int n_errors = 0;
   int pulses;

   bit [2:0] ram    [0:16383];
   bit       wr_ok  [0:16383];

   vga_vram_scheduler dut (
      .clk            (clk),
      .reset          (reset),
      .hPixel         (hPixel),
      .display_active (display_active),
      .frame_start    (frame_start),
      .host_req       (host_req),
      .host_addr      (host_addr),
      .host_wdata     (host_wdata),
      .host_ack       (host_ack),
      .mem_en         (mem_en),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .vPixel         (vPixel),
      .pix_data       (pix_data),
      .pix_valid      (pix_valid)
   );

   always #5 clk = ~clk;

   // Background image: 5 at row 3 col 0, (col*3+1) mod 8 on row 1
   function automatic logic [2:0] pat(input logic [13:0] a);
      int v;
      v = 0;
      if (a[13:7] == 7'd3 && a[6:0] == 7'd0) v = 5;
      else if (a[13:7] == 7'd1) v = int'(a[6:0]) * 3 + 1;
      return 3'(v);
   endfunction

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr]   <= mem_wdata;
            wr_ok[mem_addr] <= 1'b1;
         end else begin
            mem_rdata <= wr_ok[mem_addr] ? ram[mem_addr] : pat(mem_addr);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic line(input bit fs);
      display_active = 1'b1;
      tick();
      display_active = 1'b0;
      frame_start    = fs;
      tick();
      frame_start = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      reset          = 1'b1;
      hPixel         = '0;
      display_active = 1'b0;
      frame_start    = 1'b0;
      host_req       = 1'b0;
      host_addr      = '0;
      host_wdata     = '0;
      #3;
      check("rst_en",    32'(mem_en),    32'd0);
      check("rst_we",    32'(mem_we),    32'd0);
      check("rst_ack",   32'(host_ack),  32'd0);
      check("rst_pv",    32'(pix_valid), 32'd0);
      check("rst_pd",    32'(pix_data),  32'd0);
      check("rst_vpix",  32'(vPixel),    32'd0);
      check("rst_addr",  32'(mem_addr),  32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();

      repeat (5) line(1'b0);
      check("row_1", 32'(vPixel), 32'd1);
      repeat (10) line(1'b0);
      check("row_3", 32'(vPixel), 32'd3);

      // Single display read at row 3, column 0
      hPixel         = 7'd0;
      display_active = 1'b1;
      tick();
      check("rd_en",   32'(mem_en),   32'd1);
      check("rd_we",   32'(mem_we),   32'd0);
      check("rd_addr", 32'(mem_addr), 32'h180);
      tick();
      check("rd_pv_e2", 32'(pix_valid), 32'd0);
      tick();
      check("rd_pv_e3", 32'(pix_valid), 32'd1);
      check("rd_pd",    32'(pix_data),  32'd5);
      tick();
      check("rd_pv_e4", 32'(pix_valid), 32'd0);
      repeat (10) tick();

      // Column change and host request in the same cycle
      hPixel     = 7'd1;
      host_req   = 1'b1;
      host_addr  = 14'h0042;
      host_wdata = 3'd6;
      tick();
      check("col_rd_en",   32'(mem_en),   32'd1);
      check("col_rd_we",   32'(mem_we),   32'd0);
      check("col_rd_addr", 32'(mem_addr), 32'h181);
      check("col_ack_t1",  32'(host_ack), 32'd0);
      tick();
      check("col_cap_en",  32'(mem_en),   32'd0);
      check("col_ack_t2",  32'(host_ack), 32'd0);
      tick();
      check("col_ack_t3",  32'(host_ack),  32'd1);
      check("col_wr_we",   32'(mem_we),    32'd1);
      check("col_wr_addr", 32'(mem_addr),  32'h42);
      check("col_wr_data", 32'(mem_wdata), 32'd6);
      check("col_pv",      32'(pix_valid), 32'd1);
      tick();
      check("dbl_ack_t4",  32'(host_ack), 32'd0);
      check("dbl_we_t4",   32'(mem_we),   32'd0);
      tick();
      check("dbl_we_t5",   32'(mem_we),   32'd0);
      host_req = 1'b0;
      tick();
      host_req   = 1'b1;
      host_addr  = 14'h0043;
      host_wdata = 3'd2;
      tick();
      check("wr2_ack",  32'(host_ack), 32'd1);
      check("wr2_we",   32'(mem_we),   32'd1);
      check("wr2_addr", 32'(mem_addr), 32'h43);
      host_req = 1'b0;
      tick();
      check("ram_42", 32'(ram[14'h0042]), 32'd6);
      check("ram_43", 32'(ram[14'h0043]), 32'd2);

      // Reset asserted in the middle of a write cycle
      display_active = 1'b0;
      repeat (3) tick();
      host_req   = 1'b1;
      host_addr  = 14'h0044;
      host_wdata = 3'd7;
      tick();
      check("mid_pre_ack", 32'(host_ack), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_ack",  32'(host_ack),  32'd0);
      check("mid_en",   32'(mem_en),    32'd0);
      check("mid_we",   32'(mem_we),    32'd0);
      check("mid_addr", 32'(mem_addr),  32'd0);
      check("mid_vpix", 32'(vPixel),    32'd0);
      check("mid_pv",   32'(pix_valid), 32'd0);
      check("mid_pd",   32'(pix_data),  32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      check("post_ack",  32'(host_ack),  32'd1);
      check("post_we",   32'(mem_we),    32'd1);
      check("post_addr", 32'(mem_addr),  32'h44);
      check("post_data", 32'(mem_wdata), 32'd7);
      tick();
      check("post_ack_1", 32'(host_ack), 32'd0);
      tick();
      check("post_ack_2", 32'(host_ack), 32'd0);
      host_req = 1'b0;
      tick();

      // Row counting, wrap and frame restart
      repeat (475) line(1'b0);
      check("wrap_95", 32'(vPixel), 32'd95);
      repeat (5) line(1'b0);
      check("wrap_0", 32'(vPixel), 32'd0);
      repeat (5) line(1'b0);
      check("wrap_1", 32'(vPixel), 32'd1);
      repeat (2) line(1'b0);
      line(1'b1);
      check("fs_vpix", 32'(vPixel), 32'd0);
      repeat (4) line(1'b0);
      check("fs_cnt4", 32'(vPixel), 32'd0);
      line(1'b0);
      check("fs_cnt5", 32'(vPixel), 32'd1);

      // Full visible line on row 1
      pulses = 0;
      for (int c = 0; c < 128; c++) begin
         hPixel         = 7'(c);
         display_active = 1'b1;
         tick();
         if (pix_valid) pulses++;
         check("fl_addr", 32'(mem_addr), 32'({7'd1, hPixel}));
         tick();
         if (pix_valid) pulses++;
         tick();
         if (pix_valid) pulses++;
         check("fl_data", 32'(pix_data), 32'(pat({7'd1, hPixel})));
         for (int k = 0; k < 17; k++) begin
            tick();
            if (pix_valid) pulses++;
         end
      end
      display_active = 1'b0;
      tick();
      tick();
      check("fl_blank",  32'(pix_data), 32'd0);
      check("fl_pulses", 32'(pulses),   32'd128);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vga_vram_scheduler.md
# vga_vram_scheduler

Schedules all accesses to the single-port synchronous video RAM that feeds the VGA pixel path. Each time the horizontal timing generator advances its 7-bit column index during the visible region, the block issues a priority display read and returns the pixel value. It also tracks the vertical pixel row from line and frame events. Host (CPU/pattern-loader) writes are interleaved into idle RAM cycles through a 4-phase request/acknowledge handshake.

## Interface

Parameters:

- `DATA_W`, 3, width of one pixel word (RGB).
- `HPIX_W`, 7, column index width (128 columns).
- `VPIX_W`, 7, row index width.
- `ROWS`, 96, visible pixel rows per frame.
- `LINES_PER_ROW`, 5, scan lines per pixel row.

Ports:

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `hPixel`  in  `HPIX_W`  current column from the horizontal timing generator.
- `display_active`  in  1  high during the visible part of a line.
- `frame_start`  in  1  one-cycle pulse at the start of vertical sync.
- `host_req`  in  1  host write request, level.
- `host_addr`  in  `HPIX_W+VPIX_W`  host write address, `{row, col}`.
- `host_wdata`  in  `DATA_W`  host write data.
- `host_ack`  out  1  one-cycle pulse when the host write is driven to RAM.
- `mem_en`  out  1  RAM access strobe.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  `HPIX_W+VPIX_W`  RAM address.
- `mem_wdata`  out  `DATA_W`  RAM write data.
- `mem_rdata`  in  `DATA_W`  RAM read data, valid the cycle after a read strobe.
- `vPixel`  out  `VPIX_W`  current pixel row.
- `pix_data`  out  `DATA_W`  pixel for the current column.
- `pix_valid`  out  1  one-cycle pulse when `pix_data` updates.

## Operation

- **Registered history.** `hPixel_q` and `active_q` hold the previous-cycle copies of `hPixel` and `display_active`.
- **Display event.** Fires when `display_active && (!active_q || hPixel != hPixel_q)`. An event sets `disp_pend`. `disp_pend` clears when the read is issued.
- **FSM states.**
  - `IDLE`:
    - `disp_pend` or an event this cycle → `RD`.
    - Else a host write is eligible → `WR`.
    - Else stay in `IDLE`.
  - `RD`: drives `mem_en=1`, `mem_we=0`, `mem_addr={vPixel, hPixel_q}`. Always → `CAP`.
  - `CAP`: `pix_data <= mem_rdata`, then `pix_valid` pulses. Next state:
    - `disp_pend` set → `RD`.
    - Else host write eligible → `WR`.
    - Else → `IDLE`.
  - `WR`: drives `mem_en=1`, `mem_we=1`, plus `host_addr` and `host_wdata`. `host_ack=1` in this cycle. `ack_seen` is set. Always → `IDLE`.
- **Host eligibility.** A host write is eligible when `host_req && !ack_seen`. `ack_seen` clears the first cycle `host_req` is low. This prevents a double write while the host is still deasserting its request.
- **Priority.** Display always beats host. A host request pending at the same decision point as a display event waits.
- **Row tracking.**
  - On a falling edge of `display_active`, `line_cnt` increments.
  - When `line_cnt` reaches `LINES_PER_ROW-1` it wraps to 0 and `vPixel` increments.
  - `vPixel` wraps from `ROWS-1` to 0.
  - `frame_start` clears both `line_cnt` and `vPixel`. It wins over a simultaneous falling edge.
- **Blanking.** On a falling edge of `display_active`, `pix_data` clears to 0 so blanking outputs black.
- **Reset values.** State `IDLE`. `pix_data`, `pix_valid`, `host_ack`, `mem_*`, `vPixel`, `line_cnt`, `disp_pend`, `ack_seen`, `hPixel_q` and `active_q` are all 0.

## Timing

- All `mem_*` outputs, `host_ack`, `pix_data` and `pix_valid` are registered.
- **Display read latency.** An event in cycle E (state `IDLE`) gives:
  - Read strobe in E+1.
  - `mem_rdata` in E+2.
  - `pix_valid` and new `pix_data` in E+3.
- **Event during `WR` or `CAP`.** The event is held in `disp_pend`. The read strobe comes at most 1 cycle later, so latency is at most 4 cycles.
- **Host write latency.** From an eligible `host_req` in `IDLE` to `host_ack` is 1 cycle when there is no display event. Worst case is 3 cycles.
- **Throughput.** Display events are ≥20 cycles apart, so a host write can complete in every gap. Host throughput is one write per 4-phase handshake (≥3 cycles).
- **Reset mid-operation.** Outputs return to reset values asynchronously. A pending host request is re-served after reset releases.

## Test plan

- **Reset.** Assert `reset` mid-`WR`. All outputs read 0 immediately and `vPixel=0`. After release, the pending `host_req` gets exactly one `host_ack`.
- **Single display read.** `vPixel=3`, `display_active` rises with `hPixel=0`. `mem_addr=0x180` and `mem_we=0` one cycle later. RAM returns 5 and `pix_data=5`, with `pix_valid` 3 cycles after the rise.
- **Collision.** A column change and `host_req` (addr `0x0042`, data 6) arrive in the same cycle. The read strobe comes first, `CAP` follows, then the write. `host_ack` lands 3 cycles after the request.
- **No double write.** Hold `host_req` high 2 cycles past `host_ack`. Exactly one `mem_we` pulse occurs. Drop `host_req`, then raise it again: a second write occurs.
- **Row wrap.** Five `display_active` falling edges give `vPixel` 0→1. After 480 lines `vPixel` wraps to 0. `frame_start` coincident with a falling edge leaves `vPixel=0` and `line_cnt=0`.
- **Full line.** 128 columns at 20 cycles each give 128 `pix_valid` pulses with addresses `{vPixel, 0..127}`. `pix_data=0` after `display_active` falls.
